cbs_credit_gate: RTL and testbench

Credit-based shaper (IEEE 802.1Qav style) gate for one traffic-class queue in the CBS path. It sits upstream of the per-port arbiter/FIFO and admits whole AXI4-Stream frames only when the class credit is non-negative. It consumes the port-side ready signal that extract_output_side_ready exports at the egress end of the same stream, and uses it to freeze credit while the port itself is stalled.

---
 rtl/cbs_pkg.sv | 19 +
 rtl/cbs_credit_counter.sv | 44 ++++
 rtl/cbs_credit_gate.sv | 69 ++++++
 tb/tb_cbs_credit_gate.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// cbs_pkg: shared state encoding, credit width default and saturating clamp for CBS shapers
package cbs_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int CBS_CREDIT_WIDTH = 32;

    // Widest credit the clamp helper supports; callers sign-extend into it.
    localparam int CBS_SAT_WIDTH = 64;

    function automatic logic signed [CBS_SAT_WIDTH-1:0] sat_clamp(
        input logic signed [CBS_SAT_WIDTH-1:0] val,
        input logic signed [CBS_SAT_WIDTH-1:0] lo,
        input logic signed [CBS_SAT_WIDTH-1:0] hi
    );
        return (val > hi) ? hi : (val < lo) ? lo : val;
    endfunction

endpackage

// File: rtl/cbs_credit_counter.sv
// cbs_credit_counter: signed credit register with prioritised update and saturation
module cbs_credit_counter
    import cbs_pkg::*;
#(
    parameter int CREDIT_WIDTH = CBS_CREDIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           output_side_ready,
    input  logic                           beat,
    input  logic                           pending,
    input  logic        [CREDIT_WIDTH-2:0] idle_slope,
    input  logic        [CREDIT_WIDTH-2:0] send_slope,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic signed [CREDIT_WIDTH-1:0] lo_credit,
    output logic signed [CREDIT_WIDTH-1:0] credit
);

    localparam int XW = CREDIT_WIDTH + 1;

    logic signed [XW-1:0]           cur;
    logic signed [XW-1:0]           raw;
    logic signed [CREDIT_WIDTH-1:0] next_credit;

    // One extra bit of headroom so credit +/- slope can never wrap before clamping
    always_comb begin
        cur         = XW'(credit);
        raw         = beat ? cur - $signed({2'b00, send_slope})
                    : (pending || credit < 0) ? cur + $signed({2'b00, idle_slope})
                    : '0;
        next_credit = CREDIT_WIDTH'(sat_clamp(CBS_SAT_WIDTH'(raw),
                                              CBS_SAT_WIDTH'(lo_credit),
                                              CBS_SAT_WIDTH'(hi_credit)));
    end

    // Credit is frozen while the port itself is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit <= '0;
        else if (output_side_ready)
            credit <= next_credit;
    end

endmodule

// File: rtl/cbs_credit_gate.sv
// cbs_credit_gate: admits whole AXI4-Stream frames only when the class credit is non-negative
module cbs_credit_gate
    import cbs_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int CREDIT_WIDTH       = CBS_CREDIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]  m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    input  logic                           output_side_ready,
    input  logic        [CREDIT_WIDTH-2:0] idle_slope,
    input  logic        [CREDIT_WIDTH-2:0] send_slope,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic signed [CREDIT_WIDTH-1:0] lo_credit,
    output logic signed [CREDIT_WIDTH-1:0] credit,
    output logic                           gate_open
);

    state_t state;
    logic   beat;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & gate_open;
    assign s_axis_tready = m_axis_tready & gate_open;
    assign beat          = s_axis_tvalid & s_axis_tready;

    // Open on a waiting frame with non-negative credit, close only after the last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gate_open <= 1'b0;
        end else if (state == IDLE && s_axis_tvalid && output_side_ready && credit >= 0) begin
            state     <= SEND;
            gate_open <= 1'b1;
        end else if (state == SEND && beat && s_axis_tlast) begin
            state     <= IDLE;
            gate_open <= 1'b0;
        end
    end

    cbs_credit_counter #(
        .CREDIT_WIDTH(CREDIT_WIDTH)
    ) u_counter (
        .clk              (clk),
        .rst              (rst),
        .output_side_ready(output_side_ready),
        .beat             (beat),
        .pending          (s_axis_tvalid),
        .idle_slope       (idle_slope),
        .send_slope       (send_slope),
        .hi_credit        (hi_credit),
        .lo_credit        (lo_credit),
        .credit           (credit)
    );

endmodule

// File: tb/tb_cbs_credit_gate.sv
// tb_cbs_credit_gate: directed vector bench for the CBS credit gate
module tb_cbs_credit_gate;

    logic               clk = 1'b0;
    logic               rst;
    logic        [7:0]  s_axis_tdata;
    logic        [0:0]  s_axis_tkeep;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic               s_axis_tlast;
    logic        [7:0]  m_axis_tdata;
    logic        [0:0]  m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic               output_side_ready;
    logic        [30:0] idle_slope;
    logic        [30:0] send_slope;
    logic signed [31:0] hi_credit;
    logic signed [31:0] lo_credit;
    logic signed [31:0] credit;
    logic               gate_open;

    int vectors = 0;
    int miscompares = 0;
    int hs_cnt = 0;
    logic [7:0] tdata_drv = 8'h00;

    typedef struct {
        logic tv, tl, mr, osr, etv, etr, eg;
        logic signed [31:0] ec;
    } vec_t;

    vec_t tbl[$];

    cbs_credit_gate dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .output_side_ready(output_side_ready),
        .idle_slope       (idle_slope),
        .send_slope       (send_slope),
        .hi_credit        (hi_credit),
        .lo_credit        (lo_credit),
        .credit           (credit),
        .gate_open        (gate_open)
    );

    always #5 clk = ~clk;

    // Counts transfers seen on the output side of the gate
    always @(posedge clk) begin
        if (m_axis_tvalid && m_axis_tready)
            hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %0d expected %0d", vectors, name, act, exp);
        end
    endtask

    task automatic add(input logic tv, tl, mr, osr, etv, etr, eg, input logic signed [31:0] ec);
        tbl.push_back('{tv, tl, mr, osr, etv, etr, eg, ec});
    endtask

    task automatic set_cfg(input logic [30:0] is, ss, input logic signed [31:0] hi, lo);
        idle_slope = is;
        send_slope = ss;
        hi_credit  = hi;
        lo_credit  = lo;
    endtask

    // Entered just after a rising edge; returns just after the next one
    task automatic step(input logic tv, tl, mr, osr, etv, etr, eg, input logic signed [31:0] ec);
        s_axis_tvalid     = tv;
        s_axis_tlast      = tl;
        m_axis_tready     = mr;
        output_side_ready = osr;
        tdata_drv         = tdata_drv + 8'd1;
        s_axis_tdata      = tdata_drv;
        @(negedge clk);
        vectors++;
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(etv));
        chk("s_tready", 32'(s_axis_tready), 32'(etr));
        chk("gate_open", 32'(gate_open), 32'(eg));
        chk("credit", credit, ec);
        chk("m_tdata", 32'(m_axis_tdata), 32'(tdata_drv));
        chk("m_tkeep", 32'(m_axis_tkeep), 32'd1);
        chk("m_tlast", 32'(m_axis_tlast), 32'(tl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        s_axis_tvalid     = 1'b0;
        s_axis_tlast      = 1'b0;
        m_axis_tready     = 1'b1;
        output_side_ready = 1'b1;
        rst               = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hs0;
        s_axis_tdata = 8'h00;
        s_axis_tkeep = 1'b1;
        set_cfg(31'd1, 31'd3, 32'sd100, -32'sd100);
        do_reset();

        // Reset state
        step(0, 0, 1, 1, 0, 0, 0, 0);

        // Four-beat frame then a one-beat frame waiting behind it
        add(1, 0, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 1, 1);
        add(1, 0, 1, 1, 1, 1, 1, -2);
        add(1, 0, 1, 1, 1, 1, 1, -5);
        add(1, 1, 1, 1, 1, 1, 1, -8);
        for (int k = 0; k < 12; k++) add(1, 0, 1, 1, 0, 0, 0, -11 + k);
        add(1, 1, 1, 1, 1, 1, 1, 1);
        add(0, 0, 1, 1, 0, 0, 0, -2);
        add(0, 0, 1, 1, 0, 0, 0, -1);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        foreach (tbl[i]) step(tbl[i].tv, tbl[i].tl, tbl[i].mr, tbl[i].osr,
                              tbl[i].etv, tbl[i].etr, tbl[i].eg, tbl[i].ec);

        // Positive credit drops to zero when queue empties; negative recovers by idle_slope
        do_reset();
        set_cfg(31'd5, 31'd0, 32'sd100, -32'sd100);
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 5);
        step(0, 0, 1, 1, 0, 0, 0, 5);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        set_cfg(31'd2, 31'd8, 32'sd100, -32'sd100);
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 2);
        step(0, 0, 1, 1, 0, 0, 0, -6);
        step(0, 0, 1, 1, 0, 0, 0, -4);
        step(0, 0, 1, 1, 0, 0, 0, -2);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);

        // Port stall freezes credit and keeps the gate shut
        do_reset();
        set_cfg(31'd1, 31'd5, 32'sd100, -32'sd100);
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 1);
        for (int k = 0; k < 10; k++) step(1, 0, 1, 0, 0, 0, 0, -4);
        for (int k = 0; k < 5; k++) step(1, 1, 1, 1, 0, 0, 0, -4 + k);
        step(1, 1, 1, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 0, 0, 0, -4);

        // Clamp at lo_credit and hi_credit
        do_reset();
        set_cfg(31'd0, 31'd60, 32'sd100, -32'sd100);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 1, 1, -60);
        step(0, 0, 1, 1, 0, 0, 0, -100);
        set_cfg(31'd200, 31'd60, 32'sd50, -32'sd100);
        step(0, 0, 1, 1, 0, 0, 0, -100);
        step(0, 0, 1, 1, 0, 0, 0, 50);
        step(0, 0, 1, 1, 0, 0, 0, 0);

        // Full-range slopes must saturate rather than wrap
        do_reset();
        set_cfg(31'd0, 31'h7fff_ffff, 32'sh7fff_ffff, 32'sh8000_0000);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 1, 1, -32'sd2147483647);
        set_cfg(31'h7fff_ffff, 31'h7fff_ffff, 32'sh7fff_ffff, 32'sh8000_0000);
        step(0, 0, 1, 1, 0, 0, 0, 32'sh8000_0000);
        step(0, 0, 1, 1, 0, 0, 0, -1);
        step(0, 0, 1, 1, 0, 0, 0, 32'sh7fff_fffe);
        step(0, 0, 1, 1, 0, 0, 0, 0);

        // Downstream back-pressure mid-frame
        do_reset();
        set_cfg(31'd1, 31'd3, 32'sd100, -32'sd100);
        hs0 = hs_cnt;
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 1);
        step(1, 0, 1, 1, 1, 1, 1, 2);
        step(1, 0, 0, 1, 1, 0, 1, -1);
        step(1, 0, 1, 1, 1, 1, 1, 0);
        step(1, 1, 0, 1, 1, 0, 1, -3);
        step(1, 1, 1, 1, 1, 1, 1, -2);
        step(0, 0, 1, 1, 0, 0, 0, -5);
        vectors++;
        chk("beat_count", hs_cnt - hs0, 3);

        // Asynchronous reset during the second beat of a five-beat frame
        do_reset();
        set_cfg(31'd1, 31'd3, 32'sd100, -32'sd100);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 1, 1, 1, 1);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_s_tready", 32'(s_axis_tready), 0);
        chk("rst_gate_open", 32'(gate_open), 0);
        chk("rst_credit", credit, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 0, 0, 0, -2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
